// File: rtl/mult8b_rev_pkg.sv
// Shared widths, LIFO entry layout and FSM state type for the reversible multiplier sequencer.
// MULT8B_SCHED_CHECK_EN widens each entry with the forward operands for replay checking.
package mult8b_rev_pkg;

   localparam int P_W      = 16;
   localparam int GARB_W   = 63;
   localparam int OP_W     = 8;
   localparam int SETTLE_W = 4;

   // entry layout, LSB first: garbage, product, then (optionally) b and a
   localparam int GARB_LSB = 0;
   localparam int P_LSB    = GARB_LSB + GARB_W;
`ifdef MULT8B_SCHED_CHECK_EN
   localparam int OPB_LSB  = P_LSB + P_W;
   localparam int OPA_LSB  = OPB_LSB + OP_W;
   localparam int ENTRY_W  = OPA_LSB + OP_W;
`else
   localparam int ENTRY_W  = P_LSB + P_W;
`endif

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FWD_SETTLE = 3'd1,
      FWD_RSP    = 3'd2,
      REV_SETTLE = 3'd3,
      REV_RSP    = 3'd4
   } sched_state_t;

endpackage

// File: rtl/mult8b_rev_lifo.sv
// Register stack holding captured forward results until they are uncomputed.
// Storage is not reset; only the occupancy count is.
module mult8b_rev_lifo
   import mult8b_rev_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] push_data,
   output logic [ENTRY_W-1:0] top,
   output logic [CW-1:0]      count
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] stack [DEPTH];
   logic [AW-1:0]      wr_idx;
   logic [AW-1:0]      top_idx;

   // count==DEPTH aliases index 0, but a push is never issued when full
   assign wr_idx  = count[AW-1:0];
   assign top_idx = wr_idx - 1'b1;
   assign top     = stack[top_idx];

   always_ff @(posedge clk) begin
      if (push) stack[wr_idx] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    count <= '0;
      else if (push) count <= count + 1'b1;
      else if (pop)  count <= count - 1'b1;
   end

endmodule

// File: rtl/mult8b_rev_sched.sv
// Sequencing master for the reversible 8-bit multiplier wrapper: forward, capture, LIFO, replay.
// Optional MULT8B_SCHED_CHECK_EN compares recovered operands against the stored originals.
//
//   state      | meaning
//   IDLE       | waiting for a request, mac_* idle at 0
//   FWD_SETTLE | operands on f_a/f_b, counting down the settle window
//   FWD_RSP    | product presented upstream until prod_ready
//   REV_SETTLE | top entry on r_p/r_garb with dir=1, counting down
//   REV_RSP    | recovered operands presented until rec_ready
module mult8b_rev_sched
   import mult8b_rev_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int SETTLE_CYC = 2,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fwd_valid,
   output logic              fwd_ready,
   input  logic [OP_W-1:0]   fwd_a,
   input  logic [OP_W-1:0]   fwd_b,
   output logic              prod_valid,
   input  logic              prod_ready,
   output logic [P_W-1:0]    prod_p,
   input  logic              unc_valid,
   output logic              unc_ready,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [OP_W-1:0]   rec_a,
   output logic [OP_W-1:0]   rec_b,
   output logic [CW-1:0]     count,
   output logic              chk_err,
   output logic              mac_dir,
   output logic [OP_W-1:0]   mac_f_a,
   output logic [OP_W-1:0]   mac_f_b,
   input  logic [P_W-1:0]    mac_f_p,
   input  logic [GARB_W-1:0] mac_f_garb,
   output logic [P_W-1:0]    mac_r_p,
   output logic [GARB_W-1:0] mac_r_garb,
   input  logic [OP_W-1:0]   mac_r_a,
   input  logic [OP_W-1:0]   mac_r_b
);

   localparam logic [CW-1:0]       DEPTH_C   = CW'(DEPTH);
   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC - 1);

   sched_state_t        state;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                settle_tc;
   logic                push;
   logic                pop;
   logic [ENTRY_W-1:0]  push_data;
   logic [ENTRY_W-1:0]  top;

   assign settle_tc = (settle_cnt == '0);
   assign push      = (state == FWD_SETTLE) && settle_tc;
   assign pop       = (state == REV_SETTLE) && settle_tc;

   assign unc_ready = (state == IDLE) && (count != '0);
   assign fwd_ready = (state == IDLE) && (count < DEPTH_C) && !(unc_valid && (count != '0));

`ifdef MULT8B_SCHED_CHECK_EN
   assign push_data = {mac_f_a, mac_f_b, mac_f_p, mac_f_garb};

   // compared while the entry is still on top, i.e. on the pop edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chk_err <= 1'b0;
      else if (pop && ({mac_r_a, mac_r_b} != top[OPB_LSB +: 2*OP_W]))
         chk_err <= 1'b1;
   end
`else
   assign push_data = {mac_f_p, mac_f_garb};
   assign chk_err   = 1'b0;
`endif

   mult8b_rev_lifo #(.DEPTH(DEPTH)) u_lifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .top       (top),
      .count     (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         mac_dir    <= 1'b0;
         mac_f_a    <= '0;
         mac_f_b    <= '0;
         mac_r_p    <= '0;
         mac_r_garb <= '0;
         prod_valid <= 1'b0;
         prod_p     <= '0;
         rec_valid  <= 1'b0;
         rec_a      <= '0;
         rec_b      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (unc_valid && unc_ready) begin
                  mac_dir    <= 1'b1;
                  mac_r_p    <= top[P_LSB +: P_W];
                  mac_r_garb <= top[GARB_LSB +: GARB_W];
                  settle_cnt <= SETTLE_LD;
                  state      <= REV_SETTLE;
               end else if (fwd_valid && fwd_ready) begin
                  mac_dir    <= 1'b0;
                  mac_f_a    <= fwd_a;
                  mac_f_b    <= fwd_b;
                  settle_cnt <= SETTLE_LD;
                  state      <= FWD_SETTLE;
               end
            end
            FWD_SETTLE: begin
               if (settle_tc) begin
                  prod_p     <= mac_f_p;
                  prod_valid <= 1'b1;
                  state      <= FWD_RSP;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            FWD_RSP: begin
               if (prod_ready) begin
                  prod_valid <= 1'b0;
                  mac_f_a    <= '0;
                  mac_f_b    <= '0;
                  state      <= IDLE;
               end
            end
            REV_SETTLE: begin
               if (settle_tc) begin
                  rec_a     <= mac_r_a;
                  rec_b     <= mac_r_b;
                  rec_valid <= 1'b1;
                  state     <= REV_RSP;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            REV_RSP: begin
               if (rec_ready) begin
                  rec_valid  <= 1'b0;
                  mac_dir    <= 1'b0;
                  mac_r_p    <= '0;
                  mac_r_garb <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult8b_rev_sched.sv
// Directed bench for mult8b_rev_sched with a behavioural reversible-multiplier macro model.
// Define MULT8B_SCHED_CHECK_EN to also exercise the operand-mismatch flag.
module tb_mult8b_rev_sched;

   localparam int DEPTH      = 4;
   localparam int SETTLE_CYC = 2;

   logic        clk;
   logic        rst_n;
   logic        fwd_valid, fwd_ready;
   logic [7:0]  fwd_a, fwd_b;
   logic        prod_valid, prod_ready;
   logic [15:0] prod_p;
   logic        unc_valid, unc_ready;
   logic        rec_valid, rec_ready;
   logic [7:0]  rec_a, rec_b;
   logic [2:0]  count;
   logic        chk_err;
   logic        mac_dir;
   logic [7:0]  mac_f_a, mac_f_b;
   logic [15:0] mac_f_p;
   logic [62:0] mac_f_garb;
   logic [15:0] mac_r_p;
   logic [62:0] mac_r_garb;
   logic [7:0]  mac_r_a, mac_r_b;
   logic        corrupt;

   int checks   = 0;
   int failures = 0;

   // macro model: garbage carries the operands so reverse mode can recover them
   assign mac_f_p    = 16'(mac_f_a) * 16'(mac_f_b);
   assign mac_f_garb = {mac_f_a, mac_f_b, 47'({3{mac_f_a ^ mac_f_b, mac_f_b}})};
   assign mac_r_a    = mac_r_garb[62:55] ^ {7'b0, corrupt};
   assign mac_r_b    = mac_r_garb[54:47];

   mult8b_rev_sched #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fwd_valid  (fwd_valid),
      .fwd_ready  (fwd_ready),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod_p     (prod_p),
      .unc_valid  (unc_valid),
      .unc_ready  (unc_ready),
      .rec_valid  (rec_valid),
      .rec_ready  (rec_ready),
      .rec_a      (rec_a),
      .rec_b      (rec_b),
      .count      (count),
      .chk_err    (chk_err),
      .mac_dir    (mac_dir),
      .mac_f_a    (mac_f_a),
      .mac_f_b    (mac_f_b),
      .mac_f_p    (mac_f_p),
      .mac_f_garb (mac_f_garb),
      .mac_r_p    (mac_r_p),
      .mac_r_garb (mac_r_garb),
      .mac_r_a    (mac_r_a),
      .mac_r_b    (mac_r_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_fwd(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                         input int hold, input string tag);
      int n;
      @(negedge clk);
      prod_ready = (hold == 0);
      fwd_a      = a;
      fwd_b      = b;
      fwd_valid  = 1'b1;
      #1 chk({tag, "_fwd_ready"}, fwd_ready, 1);
      @(posedge clk);
      #1 fwd_valid = 1'b0;
      chk({tag, "_mac_f_ab"}, {mac_f_a, mac_f_b}, {a, b});
      n = 0;
      while (!prod_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_latency"}, n, SETTLE_CYC);
      chk({tag, "_prod_p"}, prod_p, p);
      chk({tag, "_mac_dir"}, mac_dir, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "_hold_valid"}, prod_valid, 1);
         chk({tag, "_hold_p"}, prod_p, p);
         chk({tag, "_hold_fwd_ready"}, fwd_ready, 0);
         chk({tag, "_hold_unc_ready"}, unc_ready, 0);
      end
      prod_ready = 1'b1;
      @(posedge clk);
      #1 chk({tag, "_prod_done"}, prod_valid, 0);
      chk({tag, "_mac_f_clr"}, {mac_f_a, mac_f_b}, 0);
   endtask

   task automatic do_unc(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                         input bit arb, input string tag);
      int n;
      @(negedge clk);
      unc_valid = 1'b1;
      if (arb) begin
         fwd_a     = 8'h99;
         fwd_b     = 8'h99;
         fwd_valid = 1'b1;
      end
      #1 chk({tag, "_unc_ready"}, unc_ready, 1);
      if (arb) chk({tag, "_arb_fwd_ready"}, fwd_ready, 0);
      @(posedge clk);
      #1 unc_valid = 1'b0;
      fwd_valid = 1'b0;
      chk({tag, "_mac_dir_up"}, mac_dir, 1);
      chk({tag, "_mac_r_p"}, mac_r_p, p);
      chk({tag, "_mac_f_idle"}, {mac_f_a, mac_f_b}, 0);
      n = 0;
      while (!rec_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_latency"}, n, SETTLE_CYC);
      chk({tag, "_rec_ab"}, {rec_a, rec_b}, {a, b});
      @(posedge clk);
      #1 chk({tag, "_rec_done"}, rec_valid, 0);
      chk({tag, "_mac_dir_down"}, mac_dir, 0);
      chk({tag, "_mac_r_clr"}, {mac_r_p, mac_r_garb[47:0]}, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      fwd_valid  = 1'b0;
      unc_valid  = 1'b0;
      fwd_a      = '0;
      fwd_b      = '0;
      prod_ready = 1'b1;
      rec_ready  = 1'b1;
      corrupt    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_valids", {prod_valid, rec_valid}, 0);
      chk("rst_mac_dir", mac_dir, 0);
      chk("rst_prod_p", prod_p, 0);
      chk("rst_rec_ab", {rec_a, rec_b}, 0);
      chk("rst_mac_f", {mac_f_a, mac_f_b}, 0);
      chk("rst_mac_r_p", mac_r_p, 0);
      chk("rst_mac_r_garb", mac_r_garb, 0);
      chk("rst_chk_err", chk_err, 0);
      rst_n = 1'b1;

      // uncompute with nothing stored must be ignored
      @(negedge clk);
      unc_valid = 1'b1;
      #1 chk("empty_unc_ready", unc_ready, 0);
      repeat (3) @(posedge clk);
      #1 chk("empty_mac_dir", mac_dir, 0);
      chk("empty_rec_valid", rec_valid, 0);
      chk("empty_count", count, 0);
      @(negedge clk);
      unc_valid = 1'b0;

      do_fwd(8'h0F, 8'h11, 16'h00FF, 0, "f0");
      chk("f0_count", count, 1);
      do_unc(8'h0F, 8'h11, 16'h00FF, 1'b0, "u0");
      chk("u0_count", count, 0);

      do_fwd(8'h02, 8'h03, 16'h0006, 0, "f1");
      do_fwd(8'hFF, 8'hFF, 16'hFE01, 0, "f2");
      do_fwd(8'h80, 8'h02, 16'h0100, 0, "f3");
      chk("f3_count", count, 3);
      do_unc(8'h80, 8'h02, 16'h0100, 1'b0, "u3");
      do_unc(8'hFF, 8'hFF, 16'hFE01, 1'b0, "u2");
      do_unc(8'h02, 8'h03, 16'h0006, 1'b0, "u1");
      chk("u1_count", count, 0);

      do_fwd(8'h01, 8'h01, 16'h0001, 0, "d1");
      do_fwd(8'h02, 8'h02, 16'h0004, 0, "d2");
      do_fwd(8'h03, 8'h03, 16'h0009, 0, "d3");
      do_fwd(8'h04, 8'h04, 16'h0010, 0, "d4");
      chk("full_count", count, 4);
      @(negedge clk);
      fwd_a     = 8'h05;
      fwd_b     = 8'h05;
      fwd_valid = 1'b1;
      #1 chk("full_fwd_ready", fwd_ready, 0);
      repeat (2) @(posedge clk);
      #1 chk("full_not_taken", {mac_f_a, mac_f_b}, 0);
      chk("full_count_hold", count, 4);
      @(negedge clk);
      fwd_valid = 1'b0;
      do_unc(8'h04, 8'h04, 16'h0010, 1'b0, "du4");
      @(negedge clk);
      #1 chk("after_pop_fwd_ready", fwd_ready, 1);
      do_unc(8'h03, 8'h03, 16'h0009, 1'b0, "du3");
      do_unc(8'h02, 8'h02, 16'h0004, 1'b0, "du2");
      chk("drain_count", count, 1);

      do_fwd(8'h05, 8'h06, 16'h001E, 0, "f56");
      chk("arb_count", count, 2);
      do_unc(8'h05, 8'h06, 16'h001E, 1'b1, "arb");
      chk("arb_count_after", count, 1);

      do_fwd(8'h07, 8'h08, 16'h0038, 5, "bp");
      chk("bp_count", count, 2);

      // reset in the middle of a replay
      @(negedge clk);
      unc_valid = 1'b1;
      @(posedge clk);
      #1 unc_valid = 1'b0;
      chk("mid_mac_dir", mac_dir, 1);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_mac_dir", mac_dir, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_mac_r_p", mac_r_p, 0);
      chk("mid_rst_mac_r_garb", mac_r_garb, 0);
      chk("mid_rst_unc_ready", unc_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_count", count, 0);
      chk("post_rst_rec_valid", rec_valid, 0);
      chk("post_rst_fwd_ready", fwd_ready, 1);

`ifdef MULT8B_SCHED_CHECK_EN
      do_fwd(8'h12, 8'h34, 16'h03A8, 0, "cf");
      chk("cf_chk_err", chk_err, 0);
      corrupt = 1'b1;
      do_unc(8'h13, 8'h34, 16'h03A8, 1'b0, "cu");
      corrupt = 1'b0;
      chk("cu_chk_err", chk_err, 1);
      do_fwd(8'h01, 8'h02, 16'h0002, 0, "cf2");
      do_unc(8'h01, 8'h02, 16'h0002, 1'b0, "cu2");
      chk("chk_err_sticky", chk_err, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("chk_err_rst", chk_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
`else
      do_fwd(8'h12, 8'h34, 16'h03A8, 0, "cf");
      do_unc(8'h12, 8'h34, 16'h03A8, 1'b0, "cu");
      chk("chk_err_tied", chk_err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
